bandscope_sched: RTL and testbench
==================================

Name: bandscope_sched

Overview:
Capture scheduler for the bandscope sample memory.
- Generates the capture-period trigger from the main clock.
- Sequences one full-depth write burst per trigger into a ping-pong (two-bank) sample RAM.
- Publishes each completed frame to the host readout path with a ready/ack handshake.
- Sits between the ADC sample strobe, the dual-bank bandscope RAM and the host packet formatter.

Parameters:
- ADDR_W, 12: sample address width; frame depth = 2**ADDR_W (4096).
- CLK_PER_MS, 122880: main clocks per millisecond (122.88 MHz).
- DROP_W, 8: width of the dropped-frame counter.

Ports:
- clock, in, 1: main clock.
- reset, in, 1: synchronous, active-high reset.
- bs_on, in, 1: bandscope enable (level).
- bs_period, in, 8: capture period in ms; 0 is treated as 1.
- adc_valid, in, 1: one-cycle ADC sample strobe.
- host_ack, in, 1: one-cycle pulse; host has finished reading rd_bank.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_W: RAM write address.
- mem_bank, out, 1: bank currently being written.
- rd_bank, out, 1: bank holding the published frame.
- frame_ready, out, 1: published frame is available (level).
- busy, out, 1: burst in progress.
- drop_cnt, out, DROP_W: frames discarded because the host was still reading; saturating.

Behaviour:
- Reset values: all outputs 0; rd_bank=1 and mem_bank=0 (the two always differ); state IDLE; prescaler and period counters 0.
- ms tick: prescaler counts 0..CLK_PER_MS-1 and pulses tick for one cycle at the wrap. It runs only while bs_on=1; it is cleared when bs_on=0.
- Period counter:
  - Increments on tick.
  - When it reaches max(bs_period,1): trig pulses for one cycle and the counter clears.
  - A bs_period change takes effect at the next comparison. If the counter already exceeds the new value, trigger at the next tick.
- State machine (IDLE, WAIT, FILL, DONE):
  - IDLE: when bs_on=1, go to WAIT.
  - WAIT: on trig, go to FILL with mem_addr=0.
  - FILL: mem_we = adc_valid (combinational, same cycle). After each write, mem_addr increments. The write at address 2**ADDR_W-1 moves to DONE; there is no address wrap.
  - DONE (one cycle):
    - If frame_ready=0 (or host_ack is asserted this same cycle): rd_bank <= mem_bank, mem_bank <= ~mem_bank, frame_ready <= 1.
    - Otherwise: drop the frame, keep the bank, drop_cnt++ (saturates at all-ones).
    - Then go to WAIT.
- Triggers arriving while in FILL or DONE are ignored; no queueing.
- busy = 1 in FILL and DONE.
- host_ack clears frame_ready on the next edge. In DONE, ack and publish are processed ack-first, so the new frame is published. host_ack with frame_ready=0 is ignored.
- bs_on deassert in any state: next edge goes to IDLE and mem_addr=0. A partial frame is discarded and not counted. frame_ready and rd_bank are held, so the host can still finish.
- Reset mid-burst: immediate return to reset values on the next edge; mem_we is low that cycle.
- Latency:
  - trig to first possible write: 1 cycle.
  - Last write to frame_ready=1: 2 cycles (FILL to DONE to registered output).

Optional Feature:
BANDSCOPE_DECIM_EN
- Defined:
  - Adds input bs_decim [1:0].
  - In FILL, a sample is written only on every 2**bs_decim-th adc_valid. The decimation counter resets on entry to FILL.
  - bs_decim is sampled at trig and held for the burst.
- Undefined: the port is absent and every adc_valid in FILL is written.

Decomposition:
- Package bandscope_pkg:
  - state enum (IDLE, WAIT, FILL, DONE);
  - FRAME_DEPTH = 2**ADDR_W;
  - default CLK_PER_MS;
  - drop-counter saturation constant.
- Sub-module bs_period_timer:
  - contains the ms prescaler and the period counter;
  - inputs clock, reset, bs_on, bs_period; output trig.
  - It can be tested standalone with a small CLK_PER_MS.

Test Plan:
- Basic frame (CLK_PER_MS=10, bs_period=2, adc_valid every cycle): trig at cycle about 20 after bs_on → 4096 consecutive writes on addr 0..4095 to bank 0; frame_ready=1 two cycles after the last write; rd_bank=0, mem_bank=1.
- Period-0 clamp (bs_period=0): triggers every 10 clocks while idle, identical to bs_period=1.
- Host slow (no host_ack across 3 frames): frames 2 and 3 dropped, drop_cnt=2, rd_bank unchanged; then host_ack → next frame publishes to the other bank.
- Ack in DONE cycle (host_ack coincident with DONE): frame_ready stays 1, banks swap, drop_cnt unchanged.
- Abort (bs_on low at addr 1000): next cycle state IDLE, mem_addr=0, no publish, drop_cnt unchanged. After bs_on rises again, the next capture writes from addr 0.
- Decimation (macro defined, bs_decim=2, adc_valid every cycle): writes on every 4th strobe; the burst takes 16384 strobes.

Source files
------------

// File: rtl/bandscope_pkg.sv
// bandscope_pkg: capture-sequencer state type and default sizing constants
// shared by the bandscope capture scheduler and its period timer.
package bandscope_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } bs_state_t;

  localparam int BS_ADDR_W     = 12;
  localparam int FRAME_DEPTH   = 2 ** BS_ADDR_W;
  localparam int BS_CLK_PER_MS = 122880;
  localparam int BS_DROP_W     = 8;
  localparam logic [BS_DROP_W-1:0] DROP_SAT = {BS_DROP_W{1'b1}};

endpackage

// File: rtl/bandscope_sched_timer.sv
// bs_period_timer: millisecond prescaler plus capture-period counter; emits a
// one-cycle trig every max(bs_period,1) ms while the bandscope is enabled.
module bs_period_timer
  import bandscope_pkg::*;
#(
  parameter int CLK_PER_MS = BS_CLK_PER_MS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bs_on,
  input  logic [7:0] bs_period,
  output logic       trig
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] presc_r;
  logic [7:0]    per_cnt_r;
  logic          trig_r;
  logic          tick_s;
  logic [7:0]    period_eff_s;
  logic [8:0]    per_next_s;

  assign tick_s       = (presc_r == PRESC_LAST);
  assign period_eff_s = (bs_period == 8'd0) ? 8'd1 : bs_period;
  // Compare with >= so a period lowered below the running count fires on the next tick.
  assign per_next_s   = {1'b0, per_cnt_r} + 9'd1;
  assign trig         = trig_r;

  // Prescaler and period counter, both held clear while the bandscope is off.
  always_ff @(posedge clock) begin
    if (reset || !bs_on) begin
      presc_r   <= '0;
      per_cnt_r <= 8'd0;
      trig_r    <= 1'b0;
    end else begin
      trig_r <= 1'b0;
      if (tick_s) begin
        presc_r <= '0;
        if (per_next_s >= {1'b0, period_eff_s}) begin
          per_cnt_r <= 8'd0;
          trig_r    <= 1'b1;
        end else begin
          per_cnt_r <= per_next_s[7:0];
        end
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/bandscope_sched.sv
// bandscope_sched: per-trigger full-depth write burst into a ping-pong sample RAM
// and frame handoff to the host. Define BANDSCOPE_DECIM_EN to add bs_decim.
module bandscope_sched
  import bandscope_pkg::*;
#(
  parameter int ADDR_W     = BS_ADDR_W,
  parameter int CLK_PER_MS = BS_CLK_PER_MS,
  parameter int DROP_W     = BS_DROP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bs_on,
  input  logic [7:0]        bs_period,
  input  logic              adc_valid,
  input  logic              host_ack,
`ifdef BANDSCOPE_DECIM_EN
  input  logic [1:0]        bs_decim,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_bank,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  bs_state_t         state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              mem_bank_r;
  logic              rd_bank_r;
  logic              ready_r;
  logic              busy_r;
  logic [DROP_W-1:0] drop_r;
  logic              trig_s;
  logic              wr_s;
  logic              publish_s;

  bs_period_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .bs_on     (bs_on),
    .bs_period (bs_period),
    .trig      (trig_s)
  );

`ifdef BANDSCOPE_DECIM_EN
  logic [1:0] decim_r;
  logic [2:0] dec_cnt_r;
  logic [2:0] dec_mask_s;

  // Strobes skipped between written samples for the decimation latched at trig.
  always_comb begin
    dec_mask_s = 3'd0;
    case (decim_r)
      2'd0:    dec_mask_s = 3'd0;
      2'd1:    dec_mask_s = 3'd1;
      2'd2:    dec_mask_s = 3'd3;
      2'd3:    dec_mask_s = 3'd7;
      default: dec_mask_s = 3'd0;
    endcase
  end

  assign wr_s = (state_r == FILL) && adc_valid && (dec_cnt_r == dec_mask_s);
`else
  assign wr_s = (state_r == FILL) && adc_valid;
`endif

  // Ack is applied before publish, so an ack in the DONE cycle still lets the new frame through.
  assign publish_s   = !ready_r || host_ack;
  assign mem_we      = wr_s && !reset;
  assign mem_addr    = addr_r;
  assign mem_bank    = mem_bank_r;
  assign rd_bank     = rd_bank_r;
  assign frame_ready = ready_r;
  assign busy        = busy_r;
  assign drop_cnt    = drop_r;

  // Capture sequencer, bank ping-pong and host handoff.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      mem_bank_r <= 1'b0;
      rd_bank_r  <= 1'b1;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      drop_r     <= '0;
`ifdef BANDSCOPE_DECIM_EN
      decim_r    <= 2'd0;
      dec_cnt_r  <= 3'd0;
`endif
    end else begin
      if (host_ack) begin
        ready_r <= 1'b0;
      end
      if (!bs_on) begin
        state_r <= IDLE;
        addr_r  <= '0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: state_r <= WAIT;
          WAIT: begin
            if (trig_s) begin
              state_r   <= FILL;
              addr_r    <= '0;
              busy_r    <= 1'b1;
`ifdef BANDSCOPE_DECIM_EN
              decim_r   <= bs_decim;
              dec_cnt_r <= 3'd0;
`endif
            end
          end
          FILL: begin
`ifdef BANDSCOPE_DECIM_EN
            if (adc_valid) begin
              dec_cnt_r <= wr_s ? 3'd0 : dec_cnt_r + 3'd1;
            end
`endif
            if (wr_s) begin
              if (addr_r == ADDR_LAST) begin
                state_r <= DONE;
              end else begin
                addr_r <= addr_r + ADDR_W'(1);
              end
            end
          end
          DONE: begin
            if (publish_s) begin
              rd_bank_r  <= mem_bank_r;
              mem_bank_r <= ~mem_bank_r;
              ready_r    <= 1'b1;
            end else if (drop_r != DROP_MAX) begin
              drop_r <= drop_r + DROP_W'(1);
            end
            state_r <= WAIT;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bandscope_sched.sv
// tb_bandscope_sched: table-driven start-latency vectors, directed corner sequences and
// randomized traffic, all checked every cycle against a frame-level behavioural model.
module tb_bandscope_sched;
  import bandscope_pkg::*;

  localparam int CPM = 10;
  localparam int AW  = BS_ADDR_W;
  localparam int DW  = BS_DROP_W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          bs_on = 1'b0;
  logic [7:0]    bs_period = 8'd0;
  logic          adc_valid = 1'b0;
  logic          host_ack = 1'b0;
`ifdef BANDSCOPE_DECIM_EN
  logic [1:0]    bs_decim = 2'd0;
`endif
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_bank;
  logic          rd_bank;
  logic          frame_ready;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  bandscope_sched #(.ADDR_W(AW), .CLK_PER_MS(CPM), .DROP_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bs_on       (bs_on),
    .bs_period   (bs_period),
    .adc_valid   (adc_valid),
    .host_ack    (host_ack),
`ifdef BANDSCOPE_DECIM_EN
    .bs_decim    (bs_decim),
`endif
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_bank    (mem_bank),
    .rd_bank     (rd_bank),
    .frame_ready (frame_ready),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic       drv_rst = 1'b1;
  logic       drv_on = 1'b0;
  logic [7:0] drv_per = 8'd0;
  logic       drv_valid = 1'b0;

  // Model: ms progress, elapsed ms since trigger, phase 0=off 1=armed 2=filling 3=finishing.
  int m_presc, m_ms, m_phase, m_wr, m_strobes, m_dsel, m_drop;
  bit m_trig, m_bank, m_rd, m_ready;

  function automatic int cur_decim();
`ifdef BANDSCOPE_DECIM_EN
    return int'(bs_decim);
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    bit was_ready;
    int eff;
    if (reset) begin
      m_presc = 0; m_ms = 0; m_trig = 0; m_phase = 0; m_wr = 0; m_strobes = 0; m_dsel = 0;
      m_bank = 0; m_rd = 1; m_ready = 0; m_drop = 0;
    end else begin
      was_ready = m_ready;
      if (host_ack) m_ready = 0;
      if (!bs_on) begin
        m_phase = 0;
        m_wr = 0;
      end else begin
        case (m_phase)
          0: m_phase = 1;
          1: if (m_trig) begin m_phase = 2; m_wr = 0; m_strobes = 0; m_dsel = cur_decim(); end
          2: if (adc_valid) begin
               m_strobes++;
               if (m_strobes % (1 << m_dsel) == 0) begin
                 if (m_wr == FRAME_DEPTH - 1) m_phase = 3;
                 else m_wr++;
               end
             end
          default: begin
            if (!was_ready || host_ack) begin m_ready = 1; m_rd = m_bank; m_bank = !m_bank; end
            else if (m_drop < int'(DROP_SAT)) m_drop++;
            m_phase = 1;
          end
        endcase
      end
      if (!bs_on) begin
        m_presc = 0; m_ms = 0; m_trig = 0;
      end else begin
        m_trig = 0;
        eff = (bs_period == 8'd0) ? 1 : int'(bs_period);
        if (m_presc == CPM - 1) begin
          m_presc = 0;
          m_ms++;
          if (m_ms >= eff) begin m_ms = 0; m_trig = 1; end
        end else begin
          m_presc++;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [AW+DW+4:0] exp_v, act_v;
    logic [AW-1:0]    ea;
    logic [DW-1:0]    ed;
    logic             ew;
    ea = m_wr[AW-1:0];
    ed = m_drop[DW-1:0];
    ew = !reset && (m_phase == 2) && adc_valid && ((m_strobes + 1) % (1 << m_dsel) == 0);
    exp_v = {ew, ea, m_bank, m_rd, m_ready, (m_phase >= 2), ed};
    act_v = {mem_we, mem_addr, mem_bank, rd_bank, frame_ready, busy, drop_cnt};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got we=%b addr=%0d bank=%b rd=%b rdy=%b busy=%b drop=%0d expected %h got %h",
               $time, mem_we, mem_addr, mem_bank, rd_bank, frame_ready, busy, drop_cnt, exp_v, act_v);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance model on the edge, then drive the next cycle's inputs and compare.
  task automatic step(input logic ack);
    @(posedge clock);
    model_edge();
    #1;
    reset = drv_rst; bs_on = drv_on; bs_period = drv_per; adc_valid = drv_valid; host_ack = ack;
    #1;
    check_model();
  endtask

  task automatic run_until_busy(input int budget, output int n);
    n = 0;
    while (busy !== 1'b1) begin
      if (n >= budget) begin n = -1; return; end
      step(1'b0);
      n++;
    end
  endtask

  task automatic run_until_idle(input int budget, output int n);
    n = 0;
    while (busy === 1'b1) begin
      if (n >= budget) begin n = -1; return; end
      step(1'b0);
      n++;
    end
  endtask

  task automatic run_until_addr(input int a, input int budget, output int n);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == a[AW-1:0])) begin
      if (n >= budget) begin n = -1; return; end
      step(1'b0);
      n++;
    end
  endtask

  task automatic do_reset(input logic [7:0] per);
    drv_rst = 1'b1; drv_on = 1'b0; drv_per = per; drv_valid = 1'b0;
    step(1'b0);
    drv_rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] period;
    int         exp_lat;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int n, errs, busy_cyc, wr_cnt, first_we;
    vecs[0] = '{8'd0, 11};
    vecs[1] = '{8'd1, 11};
    vecs[2] = '{8'd2, 21};
    vecs[3] = '{8'd3, 31};
    vecs[4] = '{8'd5, 51};

    do_reset(8'd0);
    step(1'b0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_mem_bank", mem_bank, 0);
    chk("reset_rd_bank", rd_bank, 1);
    chk("reset_ready", frame_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop_cnt, 0);

    // Start latency from bs_on to first FILL cycle, incl. the period-0 clamp.
    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].period);
      drv_on = 1'b1;
      step(1'b0);
      run_until_busy(200, n);
      chk("start_latency", n, vecs[i].exp_lat);
    end

    // Basic frame.
    do_reset(8'd2);
    drv_on = 1'b1; drv_valid = 1'b1;
    step(1'b0);
    run_until_busy(100, n);
    chk("basic_start", n, 21);
    errs = 0;
    for (int i = 0; i < FRAME_DEPTH; i++) begin
      if (i > 0) step(1'b0);
      if (mem_we !== 1'b1 || mem_addr != i[AW-1:0] || mem_bank !== 1'b0) errs++;
    end
    chk("basic_burst_errors", errs, 0);
    step(1'b0);
    chk("basic_done_busy", busy, 1);
    chk("basic_done_ready", frame_ready, 0);
    step(1'b0);
    chk("basic_ready", frame_ready, 1);
    chk("basic_rd_bank", rd_bank, 0);
    chk("basic_mem_bank", mem_bank, 1);

    // Host slow: two more frames dropped.
    for (int f = 0; f < 2; f++) begin
      run_until_busy(100, n);
      chk("slow_start", (n >= 0), 1);
      run_until_idle(FRAME_DEPTH + 10, n);
      chk("slow_frame_end", (n >= 0), 1);
    end
    chk("slow_drop", drop_cnt, 2);
    chk("slow_rd_bank", rd_bank, 0);
    chk("slow_mem_bank", mem_bank, 1);
    step(1'b1);
    step(1'b0);
    chk("slow_ack_clears", frame_ready, 0);
    run_until_busy(100, n);
    run_until_idle(FRAME_DEPTH + 10, n);
    step(1'b0);
    chk("slow_pub_ready", frame_ready, 1);
    chk("slow_pub_rd_bank", rd_bank, 1);
    chk("slow_pub_mem_bank", mem_bank, 0);
    chk("slow_pub_drop", drop_cnt, 2);

    // Ack coincident with DONE.
    run_until_busy(100, n);
    run_until_addr(FRAME_DEPTH - 1, FRAME_DEPTH + 10, n);
    chk("ackdone_reach_last", (n >= 0), 1);
    step(1'b1);
    chk("ackdone_in_done", busy, 1);
    step(1'b0);
    chk("ackdone_ready", frame_ready, 1);
    chk("ackdone_rd_bank", rd_bank, 0);
    chk("ackdone_mem_bank", mem_bank, 1);
    chk("ackdone_drop", drop_cnt, 2);

    // Abort at address 1000, then restart from address 0.
    run_until_busy(100, n);
    run_until_addr(1000, 2000, n);
    chk("abort_reach", (n >= 0), 1);
    drv_on = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_ready_held", frame_ready, 1);
    chk("abort_rd_bank", rd_bank, 0);
    chk("abort_drop", drop_cnt, 2);
    drv_on = 1'b1;
    step(1'b0);
    run_until_busy(100, n);
    chk("abort_restart_addr", mem_addr, 0);
    chk("abort_restart_we", mem_we, 1);

    // Reset in mid-burst.
    run_until_addr(500, 1000, n);
    drv_rst = 1'b1;
    step(1'b0);
    chk("rst_burst_we_low", mem_we, 0);
    drv_rst = 1'b0; drv_on = 1'b0;
    step(1'b0);
    chk("rst_burst_busy", busy, 0);
    chk("rst_burst_rd_bank", rd_bank, 1);
    chk("rst_burst_ready", frame_ready, 0);

`ifdef BANDSCOPE_DECIM_EN
    // Decimation by 4.
    do_reset(8'd1);
    bs_decim = 2'd2;
    drv_on = 1'b1; drv_valid = 1'b1;
    step(1'b0);
    run_until_busy(100, n);
    busy_cyc = 0; wr_cnt = 0; first_we = -1;
    while (busy === 1'b1 && busy_cyc < 20000) begin
      if (mem_we === 1'b1) begin
        if (first_we < 0) first_we = busy_cyc;
        wr_cnt++;
      end
      busy_cyc++;
      step(1'b0);
    end
    chk("decim_first_write", first_we, 3);
    chk("decim_writes", wr_cnt, FRAME_DEPTH);
    chk("decim_busy_cycles", busy_cyc, 4 * FRAME_DEPTH + 1);
    bs_decim = 2'd0;
`else
    busy_cyc = 0; wr_cnt = 0; first_we = 0;
`endif

    // Randomized traffic against the model.
    do_reset(8'd1);
    drv_on = 1'b1;
    for (int i = 0; i < 14000; i++) begin
      drv_rst = ($urandom_range(0, 4999) == 0);
      if (drv_on) drv_on = ($urandom_range(0, 2999) != 0);
      else drv_on = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) drv_per = 8'($urandom_range(0, 3));
      drv_valid = ($urandom_range(0, 9) < 7);
`ifdef BANDSCOPE_DECIM_EN
      if ($urandom_range(0, 299) == 0) bs_decim = 2'($urandom_range(0, 1));
`endif
      step($urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
